// File: rtl/handshake_buffer.sv
// Elastic valid/ready FIFO stage with fill-level reporting and synchronous flush.
// Optional zero-latency fall-through when empty: define HANDSHAKE_BUFFER_BYPASS_EN.
module handshake_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count;
    logic             empty, full, push, pop, store, unload;

    assign empty    = (count == '0);
    assign full     = (count == LW'(DEPTH));
    // Ready depends only on registered state and flush, never on out_ready.
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign level    = count;

`ifdef HANDSHAKE_BUFFER_BYPASS_EN
    logic bypass;
    assign bypass    = empty && !flush;
    assign out_valid = bypass ? in_valid : !empty;
    assign out_data  = bypass ? in_data  : mem[rd_ptr];
    // A word taken straight through in the same cycle is never stored.
    assign store     = push && !(bypass && out_ready);
    assign unload    = pop && !empty;
`else
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];
    assign store     = push;
    assign unload    = pop;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)  wr_ptr <= wr_ptr + 1'b1;
            if (unload) rd_ptr <= rd_ptr + 1'b1;
            case ({store, unload})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_handshake_buffer.sv
// Directed bench for handshake_buffer: driver queues expected words, a monitor
// pops and compares on every output handshake.
module tb_handshake_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  level;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

`ifdef HANDSHAKE_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    handshake_buffer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; returns at the falling edge so callers can check state.
    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
        if (v && in_ready) exp_q.push_back(d);
        if (f) begin
            #2;
            exp_q.delete();
        end
    endtask

    // Monitor: compares each output handshake and checks stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'b0, out_valid}, 32'd1);
                    chk("stall_data", out_data, prev_data);
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            errors++;
                            $display("FAIL out_data_order: got 0x%0h expected 0x%0h", out_data, e);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready && !flush;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, fill to full, fifth word refused
        #12;
        chk("rst_level", {29'b0, level}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        #10 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        drive(1, 32'h11, 0, 0);
        drive(1, 32'h22, 0, 0);
        drive(1, 32'h33, 0, 0);
        drive(1, 32'h44, 0, 0);
        drive(1, 32'h55, 0, 0);
        chk("full_level", {29'b0, level}, 32'd4);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1, 32'h55, 0, 0);
        chk("full_hold_level", {29'b0, level}, 32'd4);

        // 2: drain from full
        drive(0, 0, 1, 0);
        chk("drain_pop_in_ready", {31'b0, in_ready}, 32'd0);
        drive(0, 0, 1, 0);
        chk("drain_level3", {29'b0, level}, 32'd3);
        chk("drain_in_ready_back", {31'b0, in_ready}, 32'd1);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("drain_level0", {29'b0, level}, 32'd0);
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

        // 3: streaming 0..19
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'(i), 1, 0);
            chk("stream_level", {29'b0, level}, (i == 0 || BYP) ? 32'd0 : 32'd1);
        end
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("stream_end_level", {29'b0, level}, 32'd0);

        // 4: flush at level 3
        drive(1, 32'hA1, 0, 0);
        drive(1, 32'hA2, 0, 0);
        drive(1, 32'hA3, 0, 0);
        drive(1, 32'hAA, 0, 1);
        chk("flush_level_before", {29'b0, level}, 32'd3);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        drive(0, 0, 0, 0);
        chk("flush_level_after", {29'b0, level}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        drive(1, 32'hBB, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("post_flush_level", {29'b0, level}, 32'd0);

        // 5: asynchronous reset mid-cycle at level 2
        drive(1, 32'hC1, 0, 0);
        drive(1, 32'hC2, 0, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_level", {29'b0, level}, 32'd0);
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b1;
        drive(0, 0, 1, 0);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        drive(0, 0, 1, 0);
        chk("post_rst_level", {29'b0, level}, 32'd0);

        // 6: latency from empty
        drive(1, 32'h7, 1, 0);
        if (BYP) begin
            chk("bypass_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bypass_out_data", out_data, 32'h7);
            chk("bypass_level", {29'b0, level}, 32'd0);
            drive(0, 0, 1, 0);
            chk("bypass_after_valid", {31'b0, out_valid}, 32'd0);
        end else begin
            chk("lat_same_cycle_valid", {31'b0, out_valid}, 32'd0);
            drive(0, 0, 1, 0);
            chk("lat_next_valid", {31'b0, out_valid}, 32'd1);
            chk("lat_next_data", out_data, 32'h7);
            chk("lat_next_level", {29'b0, level}, 32'd1);
        end
        drive(0, 0, 0, 0);
        chk("final_level", {29'b0, level}, 32'd0);
        #2;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
